ram_hex_dumper: RTL

RAM_HEX_DUMPER -- requirements
Module: ram_hex_dumper

---
 rtl/dump_pkg.sv | 39 +++
 rtl/ram_hex_dumper_if.sv | 32 +++
 rtl/nib2ascii.sv | 11 +
 rtl/ram_hex_dumper_core.sv | 161 ++++++++++++++++
 rtl/ram_hex_dumper.sv | 57 +++++
 5 files changed

// File: rtl/dump_pkg.sv
// Shared definitions for the RAM hex dumper: FSM states, UART register
// map, LSR bit position, ASCII constants and the per-byte character slots.
// No ports; imported by the dumper core.
package dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_CAP,
    POLL,
    WR_CHR,
    NEXT,
    FINISH
  } state_t;

  // UART register addresses (16550-style map)
  localparam logic [2:0] UART_THR = 3'd0;
  localparam logic [2:0] UART_LSR = 3'd5;

  // Transmit-holding-register-empty flag inside LSR
  localparam int LSR_THRE_BIT = 5;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Character slots emitted for one RAM byte. Slots 0-2 only at the start
  // of a line, slots 6-7 only at the end of a line.
  localparam logic [2:0] CI_ADDR_HI = 3'd0;
  localparam logic [2:0] CI_ADDR_LO = 3'd1;
  localparam logic [2:0] CI_COLON   = 3'd2;
  localparam logic [2:0] CI_SPACE   = 3'd3;
  localparam logic [2:0] CI_DATA_HI = 3'd4;
  localparam logic [2:0] CI_DATA_LO = 3'd5;
  localparam logic [2:0] CI_CR      = 3'd6;
  localparam logic [2:0] CI_LF      = 3'd7;

endpackage

// File: rtl/ram_hex_dumper_if.sv
// Bus bundle between the dumper and its RAM / UART neighbours.
// master: drives RAM address/enables and UART address/data/strobes.
// slave:  returns RAM read data and UART read data.
interface ram_hex_dumper_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) ();

  logic [ADDR_WIDTH-1:0] sram_add;
  logic                  sram_cen;
  logic                  sram_wen;
  logic [DATA_WIDTH-1:0] sram_dat;

  logic [2:0]            uart_addr;
  logic [7:0]            uart_wdata;
  logic [7:0]            uart_rdata;
  logic                  uart_we;
  logic                  uart_re;

  modport master (
    output sram_add, sram_cen, sram_wen,
    output uart_addr, uart_wdata, uart_we, uart_re,
    input  sram_dat, uart_rdata
  );

  modport slave (
    input  sram_add, sram_cen, sram_wen,
    input  uart_addr, uart_wdata, uart_we, uart_re,
    output sram_dat, uart_rdata
  );

endinterface

// File: rtl/nib2ascii.sv
// Converts one hex nibble to its uppercase ASCII character (combinational).
// Ports: nib - 4-bit value; chr - ASCII '0'-'9' or 'A'-'F'.
module nib2ascii (
  input  logic [3:0] nib,
  output logic [7:0] chr
);

  // 'A' is 0x41, so values 10..15 map onto 0x37 + nib
  assign chr = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});

endmodule

// File: rtl/ram_hex_dumper_core.sv
// Dump FSM: reads RAM bytes and writes them to a UART as hex text lines.
// Ports: CLK/RESETn; start/base_addr/count request; busy/done status;
//        bus (master) carries the RAM read port and UART register port.
module ram_hex_dumper_core
  import dump_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int BYTES_PER_LINE = 16
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  ram_hex_dumper_if.master      bus
);

  localparam int LPW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
  localparam logic [LPW-1:0] LAST_POS = LPW'(BYTES_PER_LINE - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [LPW-1:0]        line_pos;
  logic [2:0]            chr_idx;
  logic [DATA_WIDTH-1:0] data_r;

  logic       line_start;
  logic       line_end;
  logic       last_byte;
  logic [7:0] sel_byte;
  logic [7:0] hi_chr;
  logic [7:0] lo_chr;
  logic [7:0] cur_chr;

  assign last_byte  = (remaining == {{ADDR_WIDTH{1'b0}}, 1'b1});
  assign line_start = (line_pos == '0);
  // The final byte always closes its line, even a short one
  assign line_end   = (line_pos == LAST_POS) || last_byte;

  // Prefix slots print the line address, data slots print the RAM byte
  assign sel_byte = (chr_idx < CI_SPACE) ? 8'(cur_addr) : 8'(data_r);

  nib2ascii u_nib_hi (.nib(sel_byte[7:4]), .chr(hi_chr));
  nib2ascii u_nib_lo (.nib(sel_byte[3:0]), .chr(lo_chr));

  always_comb begin
    cur_chr = ASCII_SPACE;
    case (chr_idx)
      CI_ADDR_HI, CI_DATA_HI: cur_chr = hi_chr;
      CI_ADDR_LO, CI_DATA_LO: cur_chr = lo_chr;
      CI_COLON:               cur_chr = ASCII_COLON;
      CI_SPACE:               cur_chr = ASCII_SPACE;
      CI_CR:                  cur_chr = ASCII_CR;
      CI_LF:                  cur_chr = ASCII_LF;
      default:                cur_chr = ASCII_SPACE;
    endcase
  end

  // Read-only client of the RAM
  assign bus.sram_wen = 1'b1;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.sram_cen   <= 1'b1;
      bus.sram_add   <= '0;
      bus.uart_we    <= 1'b0;
      bus.uart_re    <= 1'b0;
      bus.uart_addr  <= UART_THR;
      bus.uart_wdata <= 8'h00;
      cur_addr       <= '0;
      remaining      <= '0;
      line_pos       <= '0;
      chr_idx        <= '0;
      data_r         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= base_addr;
            remaining <= count;
            line_pos  <= '0;
            busy      <= 1'b1;
            if (count == '0) begin
              state <= FINISH;
            end else begin
              bus.sram_cen <= 1'b0;
              bus.sram_add <= base_addr;
              state        <= RD_REQ;
            end
          end
        end

        RD_REQ: begin
          bus.sram_cen <= 1'b1;
          state        <= RD_CAP;
        end

        RD_CAP: begin
          data_r        <= bus.sram_dat;
          chr_idx       <= line_start ? CI_ADDR_HI : CI_SPACE;
          bus.uart_re   <= 1'b1;
          bus.uart_addr <= UART_LSR;
          state         <= POLL;
        end

        // Read strobe stays high while THRE is clear: one LSR read per cycle
        POLL: begin
          if (bus.uart_rdata[LSR_THRE_BIT]) begin
            bus.uart_re    <= 1'b0;
            bus.uart_we    <= 1'b1;
            bus.uart_addr  <= UART_THR;
            bus.uart_wdata <= cur_chr;
            state          <= WR_CHR;
          end
        end

        WR_CHR: begin
          bus.uart_we <= 1'b0;
          state       <= NEXT;
        end

        NEXT: begin
          if ((chr_idx == CI_DATA_LO && !line_end) || chr_idx == CI_LF) begin
            if (last_byte) begin
              state <= FINISH;
            end else begin
              remaining    <= remaining - 1'b1;
              cur_addr     <= cur_addr + 1'b1;
              line_pos     <= line_end ? '0 : line_pos + 1'b1;
              bus.sram_cen <= 1'b0;
              bus.sram_add <= cur_addr + 1'b1;
              state        <= RD_REQ;
            end
          end else begin
            chr_idx       <= chr_idx + 3'd1;
            bus.uart_re   <= 1'b1;
            bus.uart_addr <= UART_LSR;
            state         <= POLL;
          end
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ram_hex_dumper.sv
// Top of the RAM hex dumper: flat pin-level ports around the dump core.
// Ports: CLK, RESETn, start/base_addr/count, busy/done, sram_* RAM read
//        port (RAM clocked on ~CLK), uart_* register port.
module ram_hex_dumper #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int BYTES_PER_LINE = 16
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] sram_ADD_o,
  output logic                  sram_CEN_o,
  output logic                  sram_WEN_o,
  input  logic [DATA_WIDTH-1:0] sram_DAT_i,
  output logic [2:0]            uart_addr_o,
  output logic [7:0]            uart_wdata_o,
  input  logic [7:0]            uart_rdata_i,
  output logic                  uart_we_o,
  output logic                  uart_re_o
);

  ram_hex_dumper_if #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) bus ();

  ram_hex_dumper_core #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .BYTES_PER_LINE(BYTES_PER_LINE)
  ) u_core (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .bus      (bus.master)
  );

  assign sram_ADD_o     = bus.sram_add;
  assign sram_CEN_o     = bus.sram_cen;
  assign sram_WEN_o     = bus.sram_wen;
  assign bus.sram_dat   = sram_DAT_i;
  assign uart_addr_o    = bus.uart_addr;
  assign uart_wdata_o   = bus.uart_wdata;
  assign bus.uart_rdata = uart_rdata_i;
  assign uart_we_o      = bus.uart_we;
  assign uart_re_o      = bus.uart_re;

endmodule
